store_buffer: RTL
=================

Name: store_buffer

Overview:
- Write side of the data-memory path: the store-direction counterpart of the load/immediate extension logic.
- Takes SB/SH/SW requests from the MEM stage and narrows/replicates register data into an aligned 32-bit word plus byte enables.
- Queues formatted stores in a small FIFO and drains them to data memory over a req/ack handshake.
- Flags misaligned stores as exceptions instead of queuing them.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- AW, 32, byte-address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- st_valid  input  1  MEM stage presents a store.
- st_ready  output  1  buffer can accept a store this cycle.
- st_type  input  2  00=SW, 01=SH, 10=SB, 11=reserved.
- st_addr  input  AW  byte address.
- st_data  input  32  register rt value.
- st_exc  output  1  one-cycle pulse: previous accepted store was misaligned or reserved.
- st_exc_addr  output  AW  offending address, held until the next exception.
- mem_req  output  1  head entry valid.
- mem_addr  output  AW  word-aligned address, low 2 bits are 0.
- mem_wdata  output  32  aligned write data.
- mem_be  output  4  byte enables.
- mem_ack  input  1  memory accepted the head entry.
- ld_addr  input  AW  load address probed by the MEM stage.
- ld_stall  output  1  load must wait for pending stores.
- drained  output  1  FIFO empty.

Behaviour:
- Reset (async, any time): FIFO pointers and count = 0; all pending entries discarded; outputs reset to:
  - st_ready=1, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0
  - st_exc=0, st_exc_addr=0, drained=1, ld_stall=0
- st_ready = (count != DEPTH). Derived from registered count only; no combinational path from mem_ack.
- Handshake: a store is taken when st_valid && st_ready.
  - Misaligned or reserved type: no push. Next cycle st_exc=1 for exactly one cycle and st_exc_addr=st_addr.
  - Otherwise: push the formatted entry.
- Misaligned rules: SW if addr[1:0]!=0; SH if addr[0]=1; SB never; type 11 always.
- Formatting:
  - SW: wdata=data, be=1111.
  - SH: wdata={2{data[15:0]}}, be = addr[1] ? 1100 : 0011.
  - SB: wdata={4{data[7:0]}}, be = 0001 << addr[1:0].
- Entry stores {addr[AW-1:2],2'b00, wdata, be}.
- Latency: a push into an empty FIFO shows mem_req=1 on the next cycle; there is no same-cycle bypass.
- Drain:
  - mem_req = !empty; mem_* driven from the head entry.
  - Pop on mem_req && mem_ack.
  - Head fields stay stable while mem_req=1 and mem_ack=0.
  - mem_ack while mem_req=0 is ignored.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, no push is possible (st_ready=0) even if a pop happens that cycle.
- Pointer wrap: log2(DEPTH)-bit pointers wrap naturally. Count is log2(DEPTH)+1 bits.
- drained = (count==0), registered-equivalent.
- ld_stall: see Optional Feature.

Optional Feature:
- Macro STORE_BUF_ADDR_MATCH_EN.
- Defined: ld_stall=1 iff some valid entry has word address == {ld_addr[AW-1:2],2'b00}. The compare is combinational over all DEPTH entries.
- Undefined: ld_stall = !drained (conservative: any pending store stalls every load). The compare logic is not synthesized.

Decomposition:
- Package store_pkg:
  - st_type encodings ST_SW/ST_SH/ST_SB/ST_RSV.
  - BE_WORD=4'b1111, BE_HALF_LO=4'b0011, BE_HALF_HI=4'b1100, BE_BYTE0=4'b0001.
  - Entry struct typedef.
- Sub-module store_align: purely combinational formatter. Inputs: type, addr[1:0], data. Outputs: wdata, be, misaligned. Reused by the top and by the bench scoreboard.

Test Plan:
- SB addr=0x1003, data=0x123456AB, mem_ack=1 -> next cycle mem_req=1, mem_addr=0x1000, mem_wdata=0xABABABAB, mem_be=1000; pops; drained=1 after.
- SH addr=0x2002, data=0xDEADBEEF -> mem_wdata=0xBEEFBEEF, mem_be=1100. SH addr=0x2001 -> no push, st_exc pulses 1 cycle, st_exc_addr=0x2001.
- mem_ack=0; push 4 SWs (0x10,0x14,0x18,0x1C) -> st_ready=0 after 4th; 5th st_valid stalls. Raise mem_ack for 1 cycle -> pops 0x10, st_ready=1.
- Full FIFO, push and pop same cycle -> push refused; count DEPTH-1; order 0x14,0x18,0x1C preserved across pointer wrap with subsequent pushes.
- Pending SW to 0x40, ld_addr=0x42 -> ld_stall=1 (both builds). ld_addr=0x80 -> ld_stall=1 without macro, 0 with STORE_BUF_ADDR_MATCH_EN.
- Assert reset mid-drain with 3 entries, mem_req=1 -> same cycle mem_req=0, drained=1, st_ready=1; no stale entries after reset release.

Source files
------------

// File: rtl/store_pkg.sv
// Shared store-path types: st_type encodings, byte-enable constants and the formatted payload.
package store_pkg;

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_RSV = 2'b11
  } st_type_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  // Address-independent part of a queued entry; the word address width is set by the top.
  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  be;
  } st_fmt_t;

endpackage

// File: rtl/store_align.sv
// Combinational store formatter: replicates register data across the word and builds
// byte enables from the low address bits; flags misaligned and reserved store types.
module store_align
  import store_pkg::*;
(
  input  st_type_e    st_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misaligned
);

  always_comb begin
    wdata      = data;
    be         = BE_WORD;
    misaligned = 1'b0;
    case (st_type)
      ST_SW: misaligned = (addr_lo != 2'b00);
      ST_SH: begin
        wdata      = {2{data[15:0]}};
        be         = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        misaligned = addr_lo[0];
      end
      ST_SB: begin
        wdata = {4{data[7:0]}};
        be    = BE_BYTE0 << addr_lo;
      end
      default: begin
        be         = 4'b0000;
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: formats SB/SH/SW stores, queues them in a FIFO and drains over req/ack.
// Define STORE_BUF_ADDR_MATCH_EN for per-entry load-address matching on ld_stall.
module store_buffer
  import store_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [1:0]    st_type,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  output logic          st_exc,
  output logic [AW-1:0] st_exc_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_stall,
  output logic          drained
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  typedef struct packed {
    logic [AW-1:2] waddr;
    st_fmt_t       fmt;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          st_exc_q;
  logic [AW-1:0] st_exc_addr_q;

  st_type_e    st_kind;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_be;
  logic        fmt_misaligned;
  logic        take, push, pop, empty;
  entry_t      head, entry_new;

  assign st_kind = st_type_e'(st_type);

  store_align u_align (
    .st_type    (st_kind),
    .addr_lo    (st_addr[1:0]),
    .data       (st_data),
    .wdata      (fmt_wdata),
    .be         (fmt_be),
    .misaligned (fmt_misaligned)
  );

  assign empty    = (count_q == '0);
  assign st_ready = (count_q != FULL_CNT);
  assign take     = st_valid && st_ready;
  assign push     = take && !fmt_misaligned;
  assign pop      = !empty && mem_ack;

  assign entry_new.waddr     = st_addr[AW-1:2];
  assign entry_new.fmt.wdata = fmt_wdata;
  assign entry_new.fmt.be    = fmt_be;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      st_exc_q      <= 1'b0;
      st_exc_addr_q <= '0;
    end else begin
      count_q  <= count_d;
      st_exc_q <= take && fmt_misaligned;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (take && fmt_misaligned) st_exc_addr_q <= st_addr;
    end
  end

  // Entry storage is not reset: an entry is only observed while count marks it valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_new;
  end

  assign head        = mem_q[rd_ptr_q];
  assign mem_req     = !empty;
  assign mem_addr    = empty ? '0 : {head.waddr, 2'b00};
  assign mem_wdata   = empty ? '0 : head.fmt.wdata;
  assign mem_be      = empty ? '0 : head.fmt.be;
  assign drained     = empty;
  assign st_exc      = st_exc_q;
  assign st_exc_addr = st_exc_addr_q;

`ifdef STORE_BUF_ADDR_MATCH_EN
  logic unused_ld_lo;
  assign unused_ld_lo = ^ld_addr[1:0];

  always_comb begin
    logic [PW-1:0] off;
    ld_stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      // Slot i is valid when its distance from the head is below the count.
      off = PW'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) && (mem_q[i].waddr == ld_addr[AW-1:2])) ld_stall = 1'b1;
    end
  end
`else
  logic unused_ld_addr;
  assign unused_ld_addr = ^ld_addr;
  assign ld_stall       = !empty;
`endif

endmodule
